// File: rtl/fpu_issue_arb_if.sv
// Signal bundle for the FPU issue arbiter: two request ports, the tagged
// response, and the FPU operand/result bus.
interface fpu_issue_arb_if #(
  parameter int NOPS = 10
);
  logic            rq0_valid;
  logic            rq0_ready;
  logic [3:0]      rq0_op;
  logic [31:0]     rq0_a;
  logic [31:0]     rq0_b;
  logic [7:0]      rq0_c;

  logic            rq1_valid;
  logic            rq1_ready;
  logic [3:0]      rq1_op;
  logic [31:0]     rq1_a;
  logic [31:0]     rq1_b;
  logic [7:0]      rq1_c;

  logic            rs_valid;
  logic            rs_id;
  logic [31:0]     rs_data;
  logic            rs_err;
  logic            rs_timeout;

  logic [31:0]     fpu_data_a;
  logic [31:0]     fpu_data_b;
  logic [7:0]      fpu_data_c;
  logic [NOPS-1:0] fpu_in_valid;
  logic [31:0]     fpu_out;
  logic            fpu_out_valid;

  // Arbiter side.
  modport slave (
    input  rq0_valid, rq0_op, rq0_a, rq0_b, rq0_c,
    input  rq1_valid, rq1_op, rq1_a, rq1_b, rq1_c,
    output rq0_ready, rq1_ready,
    output rs_valid, rs_id, rs_data, rs_err, rs_timeout,
    output fpu_data_a, fpu_data_b, fpu_data_c, fpu_in_valid,
    input  fpu_out, fpu_out_valid
  );

  // Requester / FPU side.
  modport master (
    output rq0_valid, rq0_op, rq0_a, rq0_b, rq0_c,
    output rq1_valid, rq1_op, rq1_a, rq1_b, rq1_c,
    input  rq0_ready, rq1_ready,
    input  rs_valid, rs_id, rs_data, rs_err, rs_timeout,
    input  fpu_data_a, fpu_data_b, fpu_data_c, fpu_in_valid,
    output fpu_out, fpu_out_valid
  );
endinterface

// File: rtl/fpu_issue_arb.sv
// Two-port round-robin issue controller for the shared FPU: grants one request,
// pulses the selected FPU op, waits (with timeout) for the result and returns it.
//
// state | meaning
// IDLE  | waiting for a request; ready is offered to the granted port
// ISSUE | one-hot start pulse on fpu_in_valid, timeout counter cleared
// WAIT  | waiting for fpu_out_valid or the timeout limit
// DONE  | one-cycle response strobe on rs_valid
module fpu_issue_arb #(
  parameter int NOPS    = 10,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             rstn,
  fpu_issue_arb_if.slave  bus
);

  localparam int unsigned NOPS_U = NOPS;
  localparam logic [7:0]  TMO    = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t      state;
  logic        last;
  logic [7:0]  cnt;
  logic        id_q;

  logic        gnt0;
  logic        gnt1;
  logic        acc;
  logic        acc_id;
  logic [3:0]  acc_op;
  logic [31:0] acc_a;
  logic [31:0] acc_b;
  logic [7:0]  acc_c;
  logic        op_legal;

  // With both ports requesting, the port that did not win last time goes next.
  assign gnt1 = bus.rq1_valid && (!bus.rq0_valid || !last);
  assign gnt0 = bus.rq0_valid && !gnt1;

  assign bus.rq0_ready = (state == IDLE) && gnt0;
  assign bus.rq1_ready = (state == IDLE) && gnt1;

  assign acc      = bus.rq0_ready || bus.rq1_ready;
  assign acc_id   = gnt1;
  assign acc_op   = gnt1 ? bus.rq1_op : bus.rq0_op;
  assign acc_a    = gnt1 ? bus.rq1_a  : bus.rq0_a;
  assign acc_b    = gnt1 ? bus.rq1_b  : bus.rq0_b;
  assign acc_c    = gnt1 ? bus.rq1_c  : bus.rq0_c;
  assign op_legal = 32'(acc_op) < NOPS_U;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      last             <= 1'b1;
      cnt              <= 8'd0;
      id_q             <= 1'b0;
      bus.fpu_in_valid <= '0;
      bus.fpu_data_a   <= 32'd0;
      bus.fpu_data_b   <= 32'd0;
      bus.fpu_data_c   <= 8'd0;
      bus.rs_valid     <= 1'b0;
      bus.rs_id        <= 1'b0;
      bus.rs_data      <= 32'd0;
      bus.rs_err       <= 1'b0;
      bus.rs_timeout   <= 1'b0;
    end else begin
      bus.fpu_in_valid <= '0;
      case (state)
        IDLE: begin
          if (acc) begin
            id_q <= acc_id;
            last <= acc_id;
            if (op_legal) begin
              bus.fpu_data_a   <= acc_a;
              bus.fpu_data_b   <= acc_b;
              bus.fpu_data_c   <= acc_c;
              bus.fpu_in_valid <= NOPS'(1) << acc_op;
              state            <= ISSUE;
            end else begin
              // Illegal op never touches the FPU; answer straight away.
              bus.rs_valid   <= 1'b1;
              bus.rs_id      <= acc_id;
              bus.rs_data    <= 32'd0;
              bus.rs_err     <= 1'b1;
              bus.rs_timeout <= 1'b0;
              state          <= DONE;
            end
          end
        end
        ISSUE: begin
          cnt   <= 8'd0;
          state <= WAIT;
        end
        WAIT: begin
          // A result arriving on the timeout cycle still wins.
          if (bus.fpu_out_valid) begin
            bus.rs_valid   <= 1'b1;
            bus.rs_id      <= id_q;
            bus.rs_data    <= bus.fpu_out;
            bus.rs_err     <= 1'b0;
            bus.rs_timeout <= 1'b0;
            state          <= DONE;
          end else if (cnt == TMO) begin
            bus.rs_valid   <= 1'b1;
            bus.rs_id      <= id_q;
            bus.rs_data    <= 32'd0;
            bus.rs_err     <= 1'b0;
            bus.rs_timeout <= 1'b1;
            state          <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          bus.rs_valid   <= 1'b0;
          bus.rs_id      <= 1'b0;
          bus.rs_data    <= 32'd0;
          bus.rs_err     <= 1'b0;
          bus.rs_timeout <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_arb.sv
// Directed bench for fpu_issue_arb: a cycle-scheduled transaction model checks
// every cycle, and the directed scenarios pin the model with literal values.
module tb_fpu_issue_arb;

  localparam int NOPS = 10;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fpu_issue_arb_if #(.NOPS(NOPS)) bus ();

  fpu_issue_arb #(.NOPS(NOPS), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- FPU responder ----------------
  int          fpu_lat = 0;      // cycles from start pulse to strobe; 0 = silent
  logic [31:0] fpu_res_val = 32'd0;
  bit          res_mix = 1'b0;
  bit          man_strobe = 1'b0;
  logic [31:0] man_data = 32'd0;
  int          pend_cnt = 0;
  logic [31:0] pend_res = 32'd0;

  always @(posedge clk) begin : responder
    bit fire;
    #2;
    fire = 1'b0;
    if (!rstn) begin
      pend_cnt = 0;
    end else begin
      if (pend_cnt > 0) begin
        pend_cnt--;
        fire = (pend_cnt == 0);
      end
      if ((|bus.fpu_in_valid) && fpu_lat > 0) begin
        pend_cnt = fpu_lat;
        pend_res = res_mix ? (fpu_res_val ^ bus.fpu_data_a) : fpu_res_val;
      end
    end
    bus.fpu_out_valid = fire || man_strobe;
    bus.fpu_out       = fire ? pend_res : man_data;
  end

  // ---------------- transaction model + per-cycle compare ----------------
  typedef struct packed {
    logic        v;
    logic        id;
    logic [31:0] data;
    logic        err;
    logic        tmo;
  } rsp_t;

  typedef struct packed {
    logic [NOPS-1:0] pulse;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [7:0]      c;
  } iss_t;

  rsp_t exp_rs  [int];
  iss_t exp_iss [int];
  int   cyc = 0;
  bit   m_last = 1'b1;
  bit   pending = 1'b0;
  bit   pend_id = 1'b0;
  int   free_at = 0;
  int   win_lo = 0;
  int   win_hi = 0;

  always @(negedge clk) begin : cmp
    rsp_t er;
    iss_t ei;
    bit   idle, w0, w1, winner;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic [7:0]  c;
    logic [NOPS-1:0] one;
    cyc++;
    if (!rstn) begin
      check("rst_rs_valid", bus.rs_valid, 0);
      check("rst_rs_data", bus.rs_data, 0);
      check("rst_pulse", bus.fpu_in_valid, 0);
      check("rst_fpu_a", bus.fpu_data_a, 0);
      exp_rs.delete();
      exp_iss.delete();
      m_last  = 1'b1;
      pending = 1'b0;
      free_at = 0;
    end else begin
      er = exp_rs.exists(cyc)  ? exp_rs[cyc]  : '0;
      ei = exp_iss.exists(cyc) ? exp_iss[cyc] : '0;
      check("m_rs_valid", bus.rs_valid, er.v);
      if (er.v) begin
        check("m_rs_id", bus.rs_id, er.id);
        check("m_rs_data", bus.rs_data, er.data);
        check("m_rs_err", bus.rs_err, er.err);
        check("m_rs_timeout", bus.rs_timeout, er.tmo);
      end
      check("m_pulse", bus.fpu_in_valid, ei.pulse);
      check("m_pulse_onehot", $onehot0(bus.fpu_in_valid), 1);
      if (ei.pulse != '0) begin
        check("m_fpu_a", bus.fpu_data_a, ei.a);
        check("m_fpu_b", bus.fpu_data_b, ei.b);
        check("m_fpu_c", bus.fpu_data_c, ei.c);
      end

      idle   = !pending && (cyc >= free_at);
      w0     = idle && bus.rq0_valid;
      w1     = idle && bus.rq1_valid;
      winner = (w0 && w1) ? !m_last : w1;
      check("m_ready0", bus.rq0_ready, w0 && !winner);
      check("m_ready1", bus.rq1_ready, w1 && winner);

      if (pending) begin
        if (cyc >= win_lo && bus.fpu_out_valid) begin
          exp_rs[cyc+1] = '{1'b1, pend_id, bus.fpu_out, 1'b0, 1'b0};
          pending = 1'b0;
          free_at = cyc + 2;
        end else if (cyc == win_hi) begin
          exp_rs[cyc+1] = '{1'b1, pend_id, 32'd0, 1'b0, 1'b1};
          pending = 1'b0;
          free_at = cyc + 2;
        end
      end else if (w0 || w1) begin
        op = winner ? bus.rq1_op : bus.rq0_op;
        a  = winner ? bus.rq1_a  : bus.rq0_a;
        b  = winner ? bus.rq1_b  : bus.rq0_b;
        c  = winner ? bus.rq1_c  : bus.rq0_c;
        m_last = winner;
        if (int'(op) < NOPS) begin
          one = 1;
          exp_iss[cyc+1] = '{one << op, a, b, c};
          pending = 1'b1;
          pend_id = winner;
          win_lo  = cyc + 2;
          win_hi  = cyc + 2 + TMO;
        end else begin
          exp_rs[cyc+1] = '{1'b1, winner, 32'd0, 1'b1, 1'b0};
          free_at = cyc + 2;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input bit v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [7:0] c);
    if (port) begin
      bus.rq1_valid = v; bus.rq1_op = op; bus.rq1_a = a; bus.rq1_b = b; bus.rq1_c = c;
    end else begin
      bus.rq0_valid = v; bus.rq0_op = op; bus.rq0_a = a; bus.rq0_b = b; bus.rq0_c = c;
    end
  endtask

  task automatic load_port(input bit port, input int n);
    drive(port, 1'b1, 4'(n*3 + 1 + int'(port)),
          (port ? 32'h2000_0000 : 32'h1000_0000) + 32'(n),
          32'h0000_0100 + 32'(n), 8'(n + 16));
  endtask

  // Issues one request on an idle DUT and returns cycles from accept to rs_valid.
  task automatic single(input string nm, input bit port, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [7:0] c,
                        input logic [31:0] ed, input bit ee, input bit et, output int lat);
    drive(port, 1'b1, op, a, b, c);
    #1;
    check({nm, "_ready"}, port ? bus.rq1_ready : bus.rq0_ready, 1);
    lat = -1;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      tick();
      if (k == 1) drive(port, 1'b0, 4'd0, 32'd0, 32'd0, 8'd0);
      if (bus.rs_valid) begin
        lat = k;
        check({nm, "_id"}, bus.rs_id, port);
        check({nm, "_data"}, bus.rs_data, ed);
        check({nm, "_err"}, bus.rs_err, ee);
        check({nm, "_timeout"}, bus.rs_timeout, et);
      end
    end
    tick();
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    int got;
    int n0, n1;
    bit g0, g1;
    int grants[$];
    drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 8'd0);
    drive(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    check("init_rs_valid", bus.rs_valid, 0);
    check("init_pulse", bus.fpu_in_valid, 0);
    rstn = 1'b1;
    tick();

    // Single request, op 3, FPU answers two cycles after the pulse.
    fpu_lat = 2; fpu_res_val = 32'h4040_0000; res_mix = 1'b0;
    drive(1'b0, 1'b1, 4'd3, 32'h3F80_0000, 32'h4000_0000, 8'h00);
    #1;
    check("t1_ready0", bus.rq0_ready, 1);
    check("t1_ready1", bus.rq1_ready, 0);
    tick(); bus.rq0_valid = 1'b0;
    check("t1_pulse", bus.fpu_in_valid, 32'h008);
    check("t1_fpu_a", bus.fpu_data_a, 32'h3F80_0000);
    tick();
    check("t1_pulse_end", bus.fpu_in_valid, 0);
    tick();
    tick();
    check("t1_rs_valid", bus.rs_valid, 1);
    check("t1_rs_id", bus.rs_id, 0);
    check("t1_rs_data", bus.rs_data, 32'h4040_0000);
    check("t1_rs_err", bus.rs_err, 0);
    check("t1_rs_timeout", bus.rs_timeout, 0);
    tick();
    check("t1_rs_one_cycle", bus.rs_valid, 0);
    tick();

    // Illegal op from port 1.
    drive(1'b1, 1'b1, 4'd12, 32'h1111_1111, 32'h2222_2222, 8'h33);
    #1;
    check("ill_ready1", bus.rq1_ready, 1);
    tick(); bus.rq1_valid = 1'b0;
    check("ill_rs_valid", bus.rs_valid, 1);
    check("ill_rs_id", bus.rs_id, 1);
    check("ill_rs_err", bus.rs_err, 1);
    check("ill_rs_data", bus.rs_data, 0);
    check("ill_pulse", bus.fpu_in_valid, 0);
    tick();
    check("ill_rs_end", bus.rs_valid, 0);
    tick();

    // Contention: both ports valid for four operations.
    fpu_lat = 2; fpu_res_val = 32'hA5A5_0000; res_mix = 1'b1;
    n0 = 0; n1 = 0;
    load_port(1'b0, n0);
    load_port(1'b1, n1);
    for (int i = 0; i < 60 && grants.size() < 4; i++) begin
      #1;
      g0 = bus.rq0_ready;
      g1 = bus.rq1_ready;
      if (g0) grants.push_back(0);
      if (g1) grants.push_back(1);
      tick();
      if (g0) begin n0++; load_port(1'b0, n0); end
      if (g1) begin n1++; load_port(1'b1, n1); end
    end
    bus.rq0_valid = 1'b0;
    bus.rq1_valid = 1'b0;
    check("cont_grant_count", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++)
      check($sformatf("cont_grant%0d", i), grants[i], i % 2);
    repeat (6) tick();

    // Timeout with a silent FPU, then a late strobe that must be dropped.
    fpu_lat = 0; res_mix = 1'b0;
    drive(1'b0, 1'b1, 4'd5, 32'hCAFE_0001, 32'hCAFE_0002, 8'h05);
    got = -1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1) bus.rq0_valid = 1'b0;
      if (k == 12) begin man_strobe = 1'b1; man_data = 32'hDEAD_BEEF; end
      if (k == 13) begin
        man_strobe = 1'b0;
        check("tmo_late_strobe_ignored", bus.rs_valid, 0);
      end
      if (bus.rs_valid && got < 0) begin
        got = k;
        check("tmo_flag", bus.rs_timeout, 1);
        check("tmo_data", bus.rs_data, 0);
        check("tmo_err", bus.rs_err, 0);
      end
    end
    check("tmo_latency", got, 11);
    fpu_lat = 2; fpu_res_val = 32'h1234_5678;
    single("after_tmo", 1'b1, 4'd9, 32'h0000_0009, 32'h0000_0090, 8'h09,
           32'h1234_5678, 1'b0, 1'b0, lat);
    check("after_tmo_latency", lat, 4);

    // Earliest honoured strobe (first WAIT cycle).
    fpu_lat = 1; fpu_res_val = 32'h0BAD_F00D;
    single("early", 1'b0, 4'd0, 32'h1, 32'h2, 8'h3, 32'h0BAD_F00D, 1'b0, 1'b0, lat);
    check("early_latency", lat, 3);

    // Strobe on the cycle the counter reaches TIMEOUT: result wins.
    fpu_lat = 9; fpu_res_val = 32'h7777_0009;
    single("edge", 1'b1, 4'd7, 32'h4, 32'h5, 8'h6, 32'h7777_0009, 1'b0, 1'b0, lat);
    check("edge_latency", lat, 11);

    // One cycle too late: timeout, strobe lands in DONE and is dropped.
    fpu_lat = 10; fpu_res_val = 32'h7777_000A;
    single("edge_late", 1'b0, 4'd1, 32'h7, 32'h8, 8'h9, 32'd0, 1'b0, 1'b1, lat);
    check("edge_late_latency", lat, 11);
    repeat (2) tick();

    // Reset during WAIT.
    fpu_lat = 0;
    drive(1'b1, 1'b1, 4'd2, 32'hCAFE_F00D, 32'hBEEF_0000, 8'h7E);
    tick(); bus.rq1_valid = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    #1;
    check("rw_rs_valid", bus.rs_valid, 0);
    check("rw_pulse", bus.fpu_in_valid, 0);
    check("rw_fpu_a", bus.fpu_data_a, 0);
    check("rw_fpu_b", bus.fpu_data_b, 0);
    check("rw_fpu_c", bus.fpu_data_c, 0);
    check("rw_rs_timeout", bus.rs_timeout, 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    man_strobe = 1'b1; man_data = 32'h5555_AAAA;
    tick();
    man_strobe = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rw_stale_ignored", bus.rs_valid, 0);
    end
    fpu_lat = 2; fpu_res_val = 32'h0000_0042;
    drive(1'b0, 1'b1, 4'd4, 32'h10, 32'h20, 8'h30);
    drive(1'b1, 1'b1, 4'd6, 32'h40, 32'h50, 8'h60);
    #1;
    check("rw_first_ready0", bus.rq0_ready, 1);
    check("rw_first_ready1", bus.rq1_ready, 0);
    tick();
    bus.rq0_valid = 1'b0;
    bus.rq1_valid = 1'b0;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
